instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 1024, which is the instruction-memory capacity in 32-bit words.
REQ-002 The block SHALL have parameter OP_CODE_LEN, default 6, which is the opcode field width and matches the processor decoder.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  requests a new program load; sampled only in IDLE.
REQ-006 in_valid / in_ready  input / output  1 / 1  instruction-field handshake; a beat transfers when both are 1.
REQ-007 in_last  input  1  marks the final instruction of the program.
REQ-008 in_opcode  input  OP_CODE_LEN  operation code.
REQ-009 in_dest, in_src1, in_src2  input  5 each  register numbers.
REQ-010 in_imm  input  16  immediate value or offset.
REQ-011 mem_we, mem_addr, mem_wdata  output  1 / 32 / 32  instruction-memory write port; mem_addr is a byte address.
REQ-012 cpu_hold  output  1  while 1, keeps the processor's fetch frozen.
REQ-013 busy, done  output  1 / 1  busy means a load is in progress; done is a one-cycle completion pulse.
REQ-014 word_count  output  $clog2(MEM_DEPTH)+1  number of words written by the current or most recent load.
REQ-015 err_overflow, err_opcode  output  1 / 1  sticky error flags, cleared on start.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, DRAIN and DONE.
REQ-017 IDLE SHALL drive in_ready=0, cpu_hold=0 and busy=0.
REQ-018 In IDLE, start=1 SHALL move to LOAD and clear word_count, both error flags and the address counter.
REQ-019 LOAD SHALL drive in_ready=1, cpu_hold=1 and busy=1.
REQ-020 When a beat is accepted in cycle N, the block SHALL set mem_we=1 in cycle N+1, with mem_addr = 4*word_count (value before increment) and mem_wdata = the packed word; word_count SHALL increment at the end of cycle N+1.
REQ-021 Back-to-back accepted beats SHALL produce back-to-back writes at consecutive addresses with no bubbles.
REQ-022 For R-format opcodes (ADD, SUB, AND, OR, NOR, XOR, SLA, SLL, SRA, SRL) the packed word SHALL be {opcode, dest, src1, src2, 11'b0}.
REQ-023 For I-format opcodes (ADDI, SUBI, LD, ST, BEZ, BNE, JMP) the packed word SHALL be {opcode, dest, src1, imm}.
REQ-024 For opcode NOP (0) the packed word SHALL be 32'd0.
REQ-025 An unrecognised opcode SHALL be written as 32'd0 and SHALL set err_opcode.
REQ-026 Acceptance of a beat with in_last=1 SHALL move the FSM to DRAIN, where in_ready=0, cpu_hold=1 and the final write completes.
REQ-027 DRAIN SHALL move to DONE after exactly one cycle.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, with cpu_hold=0 and busy=0, and SHALL then return to IDLE.
REQ-029 Total latency SHALL be: last beat accepted in cycle N, final write in cycle N+1, done in cycle N+2.
REQ-030 A beat accepted when word_count equals MEM_DEPTH SHALL NOT be written and SHALL set err_overflow; such beats are still consumed, and in_last still ends the load.
REQ-031 The block SHALL ignore start while busy=1, and SHALL ignore in_valid in IDLE, DRAIN and DONE.
REQ-032 word_count SHALL hold its value in IDLE until the next start.
REQ-033 mem_we SHALL never be 1 in IDLE or DONE.

Reset
REQ-034 With rst=0 at a clock edge, the FSM SHALL go to IDLE, and every output and counter SHALL go to 0 (mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, in_ready, word_count, both error flags).
REQ-035 Reset asserted mid-load SHALL abort the load immediately, with no further writes, and done SHALL NOT be pulsed.

Structure
REQ-036 A shared package SHALL hold the OP_* opcode constants shared with the decoder, OP_CODE_LEN, the field bit positions (opcode [31:26], dest [25:21], src1 [20:16], src2 [15:11], imm [15:0]) and the FSM state encoding.
REQ-037 Packing SHALL be a combinational sub-module named instr_pack: fields in; packed word and an illegal-opcode flag out.

Verification
REQ-038 Three-word program: start, then beats ADD (1,2,3), ADDI (4,1, imm 16'h0005), JMP (imm 16'hFFFE) with in_last on the third, all back-to-back. Required: writes at addresses 0, 4 and 8 in consecutive cycles; data {OP_ADD,5'd1,5'd2,5'd3,11'd0}, then {OP_ADDI,5'd4,5'd1,16'h0005}, then {OP_JMP,10'd0,16'hFFFE}; done two cycles after the last accept; word_count=3.
REQ-039 in_valid toggled 1,0,1,0 for two beats. Required: writes only in the cycles following acceptance, at addresses 0 and 4; no write during the gaps.
REQ-040 MEM_DEPTH=4 with 6 beats. Required: exactly 4 writes (addresses 0 to 12); err_overflow=1; done pulses; word_count=4.
REQ-041 Unknown opcode 6'h3F in the second of three beats. Required: word 1 written as 32'd0; err_opcode=1; the other words packed correctly.
REQ-042 rst=0 asserted after two of five beats. Required: every output is 0 next cycle; no further mem_we; done never pulses; a new start then begins again at address 0.
REQ-043 start pulsed again during LOAD. Required: no effect on address, word_count or state.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader and the processor decoder:
// opcode values, instruction field positions and the loader FSM encoding.
package instr_loader_pkg;

    localparam int OP_CODE_LEN = 6;

    // Instruction word field positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int DEST_MSB = 25;
    localparam int DEST_LSB = 21;
    localparam int SRC1_MSB = 20;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_MSB = 15;
    localparam int SRC2_LSB = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef logic [OP_CODE_LEN-1:0] opcode_t;

    // Opcode values, shared with the decoder
    localparam opcode_t OP_NOP  = 6'd0;
    localparam opcode_t OP_ADD  = 6'd1;
    localparam opcode_t OP_SUB  = 6'd2;
    localparam opcode_t OP_AND  = 6'd3;
    localparam opcode_t OP_OR   = 6'd4;
    localparam opcode_t OP_NOR  = 6'd5;
    localparam opcode_t OP_XOR  = 6'd6;
    localparam opcode_t OP_SLA  = 6'd7;
    localparam opcode_t OP_SLL  = 6'd8;
    localparam opcode_t OP_SRA  = 6'd9;
    localparam opcode_t OP_SRL  = 6'd10;
    localparam opcode_t OP_ADDI = 6'd11;
    localparam opcode_t OP_SUBI = 6'd12;
    localparam opcode_t OP_LD   = 6'd13;
    localparam opcode_t OP_ST   = 6'd14;
    localparam opcode_t OP_BEZ  = 6'd15;
    localparam opcode_t OP_BNE  = 6'd16;
    localparam opcode_t OP_JMP  = 6'd17;

    // Loader FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Instruction encoding class of an opcode
    typedef enum logic [1:0] {
        FMT_NOP = 2'd0,
        FMT_R   = 2'd1,
        FMT_I   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_t;

    function automatic fmt_t op_format(input opcode_t op);
        fmt_t fmt;
        case (op)
            OP_NOP:                                   fmt = FMT_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
            OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL:   fmt = FMT_R;
            OP_ADDI, OP_SUBI, OP_LD, OP_ST,
            OP_BEZ, OP_BNE, OP_JMP:                   fmt = FMT_I;
            default:                                  fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Instruction-field stream from the host into the loader.
interface instr_loader_if
    import instr_loader_pkg::*;
#(
    parameter int OP_CODE_LEN = instr_loader_pkg::OP_CODE_LEN
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [OP_CODE_LEN-1:0] in_opcode;
    logic [4:0]             in_dest;
    logic [4:0]             in_src1;
    logic [4:0]             in_src2;
    logic [15:0]            in_imm;

    modport master (
        output in_valid, in_last, in_opcode, in_dest, in_src1, in_src2, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_dest, in_src1, in_src2, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_loader_pack.sv
// Combinational instruction packer: places the fields of one instruction
// into a 32-bit word according to its format. NOP and unknown opcodes give
// an all-zero word; unknown opcodes also raise illegal.
module instr_pack
    import instr_loader_pkg::*;
#(
    parameter int OP_CODE_LEN = instr_loader_pkg::OP_CODE_LEN
) (
    input  logic [OP_CODE_LEN-1:0] opcode,
    input  logic [4:0]             dest,
    input  logic [4:0]             src1,
    input  logic [4:0]             src2,
    input  logic [15:0]            imm,
    output logic [31:0]            word,
    output logic                   illegal
);

    // Build the word from the fields selected by the opcode's format
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_format(opcode_t'(opcode)))
            FMT_R: begin
                word[OPC_MSB:OPC_LSB]   = opcode_t'(opcode);
                word[DEST_MSB:DEST_LSB] = dest;
                word[SRC1_MSB:SRC1_LSB] = src1;
                word[SRC2_MSB:SRC2_LSB] = src2;
            end
            FMT_I: begin
                word[OPC_MSB:OPC_LSB]   = opcode_t'(opcode);
                word[DEST_MSB:DEST_LSB] = dest;
                word[SRC1_MSB:SRC1_LSB] = src1;
                word[IMM_MSB:IMM_LSB]   = imm;
            end
            FMT_BAD: begin
                illegal = 1'b1;
            end
            default: begin
                word = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts a stream of instruction fields, packs each one
// and writes it to consecutive words of instruction memory while holding the
// processor's fetch. Writes trail acceptance by one cycle; done pulses one
// cycle after the final write.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int OP_CODE_LEN = instr_loader_pkg::OP_CODE_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    instr_loader_if.slave                in_bus,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic                         cpu_hold,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MEM_DEPTH):0]   word_count,
    output logic                         err_overflow,
    output logic                         err_opcode
);

    localparam int             AW      = $clog2(MEM_DEPTH) + 1;
    localparam logic [AW-1:0]  DEPTH_W = AW'(MEM_DEPTH);

    state_t          state_reg;
    logic            in_ready_reg;
    logic            cpu_hold_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            mem_we_reg;
    logic [31:0]     mem_addr_reg;
    logic [31:0]     mem_wdata_reg;
    logic [AW-1:0]   addr_cnt_reg;      // words accepted for writing
    logic [AW-1:0]   word_count_reg;    // words actually written
    logic            err_overflow_reg;
    logic            err_opcode_reg;

    logic            accept;
    logic            load_start;
    logic            room;
    logic [31:0]     packed_word;
    logic            illegal_op;

    // in_ready is only ever high in LOAD, so a handshake implies LOAD
    assign accept     = in_bus.in_valid & in_ready_reg;
    assign load_start = (state_reg == ST_IDLE) & start;
    // addr_cnt runs one write ahead of word_count, so it decides overflow
    assign room       = (addr_cnt_reg != DEPTH_W);

    instr_pack #(
        .OP_CODE_LEN (OP_CODE_LEN)
    ) u_pack (
        .opcode  (in_bus.in_opcode),
        .dest    (in_bus.in_dest),
        .src1    (in_bus.in_src1),
        .src2    (in_bus.in_src2),
        .imm     (in_bus.in_imm),
        .word    (packed_word),
        .illegal (illegal_op)
    );

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            in_ready_reg <= 1'b0;
            cpu_hold_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        in_ready_reg <= 1'b1;
                        cpu_hold_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept && in_bus.in_last) begin
                        state_reg    <= ST_DRAIN;
                        in_ready_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state_reg    <= ST_DONE;
                    done_reg     <= 1'b1;
                    cpu_hold_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b0;
                    cpu_hold_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port, word counters and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            addr_cnt_reg     <= '0;
            word_count_reg   <= '0;
            err_overflow_reg <= 1'b0;
            err_opcode_reg   <= 1'b0;
        end else begin
            mem_we_reg <= accept & room;
            if (accept && room) begin
                mem_addr_reg  <= 32'(addr_cnt_reg) << 2;
                mem_wdata_reg <= packed_word;
                addr_cnt_reg  <= addr_cnt_reg + AW'(1);
            end
            if (load_start) begin
                addr_cnt_reg     <= '0;
                word_count_reg   <= '0;
                err_overflow_reg <= 1'b0;
                err_opcode_reg   <= 1'b0;
            end else begin
                if (mem_we_reg) begin
                    word_count_reg <= word_count_reg + AW'(1);
                end
                if (accept && !room) begin
                    err_overflow_reg <= 1'b1;
                end
                if (accept && illegal_op) begin
                    err_opcode_reg <= 1'b1;
                end
            end
        end
    end

    assign in_bus.in_ready = in_ready_reg;
    assign mem_we          = mem_we_reg;
    assign mem_addr        = mem_addr_reg;
    assign mem_wdata       = mem_wdata_reg;
    assign cpu_hold        = cpu_hold_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign word_count      = word_count_reg;
    assign err_overflow    = err_overflow_reg;
    assign err_opcode      = err_opcode_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader (MEM_DEPTH=4). Stimulus pushes the
// expected writes and done cycles; a negedge monitor pops and compares.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;
    logic          err_overflow;
    logic          err_opcode;

    always #5 clk = ~clk;

    instr_loader_if #(.OP_CODE_LEN(OP_CODE_LEN)) bus ();

    instr_loader #(
        .MEM_DEPTH   (DEPTH),
        .OP_CODE_LEN (OP_CODE_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_bus       (bus.slave),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .err_overflow (err_overflow),
        .err_opcode   (err_opcode)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_wr_q[$];
    int  exp_done_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every write and every done pulse must match the next expectation
    always @(negedge clk) begin
        wr_t e;
        int  dc;
        if (mem_we === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h cycle=%0d", mem_addr, mem_wdata, cyc);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: cycle=%0d", cyc);
            end else begin
                dc = exp_done_q.pop_front();
                check("done_cycle", cyc, dc);
                check("done_no_we", {31'd0, mem_we}, 32'd0);
                check("done_hold", {31'd0, cpu_hold}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
    endtask

    // Present one beat, wait for acceptance, record the expected outcome
    task automatic send_beat(input opcode_t op, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [15:0] imm, input logic last,
                             input logic [31:0] exp_word);
        bit  got;
        wr_t e;
        got = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_dest   = d;
        bus.in_src1   = s1;
        bus.in_src2   = s2;
        bus.in_imm    = imm;
        bus.in_last   = last;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                got = 1'b1;
                if (exp_cnt < DEPTH) begin
                    e.addr = 32'(exp_cnt * 4);
                    e.data = exp_word;
                    e.cyc  = cyc + 1;
                    exp_wr_q.push_back(e);
                    exp_cnt++;
                end
                if (last) exp_done_q.push_back(cyc + 2);
            end
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: op=%0h cycle=%0d", op, cyc);
        end
    endtask

    // Wait for done, then check the final status of the load
    task automatic wait_done(input int wc, input logic ov, input logic oe);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: cycle=%0d", cyc);
        end
        check("word_count", 32'(word_count), 32'(wc));
        check("err_overflow", {31'd0, err_overflow}, {31'd0, ov});
        check("err_opcode", {31'd0, err_opcode}, {31'd0, oe});
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("idle_ready", {31'd0, bus.in_ready}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_word_count", 32'(word_count), 32'(wc));
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ctl"}, {27'd0, cpu_hold, busy, done, bus.in_ready, 1'b0}, 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
        check({tag, "_err"}, {30'd0, err_overflow, err_opcode}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_opcode = '0;
        bus.in_dest   = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_imm    = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b1;
        tick();

        // Three-word back-to-back program; src2/imm of the wrong format must not leak
        do_start();
        @(negedge clk);
        check("load_busy", {30'd0, busy, cpu_hold}, 32'd3);
        tick();
        send_beat(OP_ADD,  5'd1, 5'd2, 5'd3,  16'hABCD, 1'b0, {OP_ADD, 5'd1, 5'd2, 5'd3, 11'd0});
        send_beat(OP_ADDI, 5'd4, 5'd1, 5'd31, 16'h0005, 1'b0, {OP_ADDI, 5'd4, 5'd1, 16'h0005});
        send_beat(OP_JMP,  5'd0, 5'd0, 5'd0,  16'hFFFE, 1'b1, {OP_JMP, 10'd0, 16'hFFFE});
        @(negedge clk);
        check("drain_hold", {30'd0, cpu_hold, bus.in_ready}, 32'd2);
        wait_done(3, 1'b0, 1'b0);

        // Gapped valid: 1,0,1,0
        do_start();
        send_beat(OP_SUB, 5'd7, 5'd8, 5'd9, 16'h0000, 1'b0, {OP_SUB, 5'd7, 5'd8, 5'd9, 11'd0});
        tick();
        send_beat(OP_BEZ, 5'd2, 5'd3, 5'd0, 16'h0040, 1'b1, {OP_BEZ, 5'd2, 5'd3, 16'h0040});
        wait_done(2, 1'b0, 1'b0);

        // Overflow: six beats into a four-word memory
        do_start();
        for (int i = 0; i < 6; i++) begin
            send_beat(OP_LD, 5'(i), 5'(i + 1), 5'd0, 16'(16'h0100 + i), (i == 5),
                      {OP_LD, 5'(i), 5'(i + 1), 16'(16'h0100 + i)});
        end
        wait_done(4, 1'b1, 1'b0);

        // Unknown opcode in the middle
        do_start();
        send_beat(OP_SUB, 5'd3, 5'd4, 5'd5, 16'h0000, 1'b0, {OP_SUB, 5'd3, 5'd4, 5'd5, 11'd0});
        send_beat(6'h3F,  5'd9, 5'd9, 5'd9, 16'h1234, 1'b0, 32'd0);
        send_beat(OP_BNE, 5'd1, 5'd2, 5'd0, 16'h0010, 1'b1, {OP_BNE, 5'd1, 5'd2, 16'h0010});
        wait_done(3, 1'b0, 1'b1);

        // start pulsed during LOAD must be ignored; NOP packs to zero
        do_start();
        send_beat(OP_NOP, 5'd5, 5'd6, 5'd7, 16'h7777, 1'b0, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_beat(OP_ST,  5'd7, 5'd8, 5'd0, 16'h1234, 1'b0, {OP_ST, 5'd7, 5'd8, 16'h1234});
        send_beat(OP_SRA, 5'd10, 5'd11, 5'd12, 16'h0000, 1'b1, {OP_SRA, 5'd10, 5'd11, 5'd12, 11'd0});
        wait_done(3, 1'b0, 1'b0);

        // Reset in the middle of a five-beat load
        do_start();
        send_beat(OP_AND, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b0, {OP_AND, 5'd1, 5'd1, 5'd1, 11'd0});
        send_beat(OP_NOR, 5'd2, 5'd2, 5'd2, 16'h0000, 1'b0, {OP_NOR, 5'd2, 5'd2, 5'd2, 11'd0});
        bus.in_valid  = 1'b1;
        bus.in_opcode = OP_XOR;
        rst = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("abort");
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (4) tick();
        check("abort_no_done", 32'(exp_done_q.size()), 32'd0);
        do_start();
        send_beat(OP_LD, 5'd3, 5'd4, 5'd0, 16'h0008, 1'b1, {OP_LD, 5'd3, 5'd4, 16'h0008});
        wait_done(1, 1'b0, 1'b0);

        repeat (3) tick();
        check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
